seq_bit_serializer: RTL

- Parallel-in, serial-out stage directly upstream of the overlapping sequence detectors.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, on `out`.
- `out` connects to a detector's `in`.
- `bit_valid` and `last` qualify the stream for benches and for downstream framing logic.

---
 rtl/seq_bit_serializer_if.sv | 33 +++
 rtl/seq_bit_serializer.sv | 89 ++++++++
 2 files changed

// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: word load handshake plus serial stream bundle.
// master = word source / stream sink, slave = serializer.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 11
) ();
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             out;
  logic             bit_valid;
  logic             last;
  logic             busy;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  out,
    input  bit_valid,
    input  last,
    input  busy
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output out,
    output bit_valid,
    output last,
    output busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: WIDTH-bit word in, MSB-first bit stream out.
// Ports: clk, clear (sync active-high), bus (slave): data_in,
//   load_valid/load_ready handshake, out/bit_valid/last stream, busy.
// Option: SERIAL_BACK2BACK_EN allows reload on the last bit cycle.
module seq_bit_serializer #(
  parameter int   WIDTH      = 11,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic             clk,
  input logic             clear,
  seq_bit_serializer_if.slave bus
);

`ifdef SERIAL_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_IDX  = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_out;
  logic             r_bv;
  logic             r_last;

  logic w_at_last;
  logic w_ready;
  logic w_accept;

  assign w_at_last = (r_state == SHIFT)
                   && (r_cnt == LAST_IDX);

  // Reload window on the final bit only exists in back-to-back builds.
  assign w_ready = !clear
                 && ((r_state == IDLE)
                  || (B2B && w_at_last));

  assign w_accept = bus.load_valid && w_ready;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_out   <= IDLE_LEVEL;
      r_bv    <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      // MSB goes out now; shreg keeps the rest MSB-aligned.
      r_state <= SHIFT;
      r_shreg <= {bus.data_in[WIDTH-2:0], 1'b0};
      r_cnt   <= '0;
      r_out   <= bus.data_in[WIDTH-1];
      r_bv    <= 1'b1;
      r_last  <= 1'b0;
    end else if (r_state == SHIFT) begin
      if (w_at_last) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_out   <= IDLE_LEVEL;
        r_bv    <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        r_cnt   <= r_cnt + 1'b1;
        r_out   <= r_shreg[WIDTH-1];
        r_bv    <= 1'b1;
        r_last  <= (r_cnt == PRE_IDX);
      end
    end
  end

  assign bus.load_ready = w_ready;
  assign bus.out        = r_out;
  assign bus.bit_valid  = r_bv;
  assign bus.last       = r_last;
  assign bus.busy       = (r_state == SHIFT);

endmodule
